// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational execute-stage ALU between two
// requesters (port 0 = pipeline E stage, port 1 = aux/debug issue port).
//
// Flow: IDLE (arbitrate + accept) -> EXEC (ALU evaluates registered operands,
// result sampled) -> RESP (response held until the owner accepts) -> IDLE.
//
// Ports:
//   clk                 clock, rising edge
//   reset               asynchronous, active-low; clears all state
//   req_valid/req_ready per-port request handshake (req_ready one-hot or zero)
//   req_op*/a*/b*/shamt* per-port opcode, operands, shift amount (opaque)
//   rsp_valid/rsp_ready per-port response handshake (rsp_valid one-hot or zero)
//   rsp_result/rsp_ovf  captured ALU result / overflow, shared by both ports
//   rsp_id              port owning the current response
//   alu_a/b/shamt/op    registered ALU input drives (held outside EXEC)
//   alu_result/alu_ovf  ALU outputs, sampled in EXEC
//   busy                high in any state other than IDLE
// Parameter RR: 1 = round-robin on ties, 0 = fixed priority to port 0.
module alu_arbiter #(
    parameter bit RR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [4:0]  req_op0,
    input  logic [4:0]  req_op1,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_b1,
    input  logic [4:0]  req_shamt0,
    input  logic [4:0]  req_shamt1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_ovf,
    output logic        rsp_id,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_shamt,
    output logic [4:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_ovf,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       last;
    logic       owner;
    logic [1:0] grant;
    logic       grant_sel;
    logic       req_hs;
    logic       rsp_hs;

    // Grant is gated by reset so req_ready reads zero while reset is held,
    // even though the state register already sits in IDLE.
    always_comb begin
        grant = '0;
        if (state == IDLE && reset) begin
            if (req_valid == 2'b11) begin
                // last==1 means port 1 was served last, so port 0 wins.
                grant = (RR && !last) ? 2'b10 : 2'b01;
            end else begin
                grant = req_valid;
            end
        end
    end

    assign grant_sel = grant[1];
    assign req_hs    = |grant;
    assign req_ready = grant;
    assign rsp_hs    = (state == RESP) && rsp_ready[owner];
    assign rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_id    = owner;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_hs) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (rsp_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last      <= 1'b1;
            owner     <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_shamt <= '0;
            alu_op    <= '0;
        end else if (req_hs) begin
            owner     <= grant_sel;
            if (RR) last <= grant_sel;
            alu_a     <= grant_sel ? req_a1     : req_a0;
            alu_b     <= grant_sel ? req_b1     : req_b0;
            alu_shamt <= grant_sel ? req_shamt1 : req_shamt0;
            alu_op    <= grant_sel ? req_op1    : req_op0;
        end
    end

    // Result/overflow are captured once at the end of EXEC and then held
    // unchanged through RESP until the owner takes the response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_result <= '0;
            rsp_ovf    <= 1'b0;
        end else if (state == EXEC) begin
            rsp_result <= alu_result;
            rsp_ovf    <= alu_ovf;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed, table-driven bench for alu_arbiter. Two instances
// share stimulus: dut (RR=1) and dut_fp (RR=0). A small combinational ALU
// model stands in for the execute-stage ALU (op 0 add, 1 sub, 2 and, 3 shl).
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [4:0]  req_op0, req_op1;
    logic [31:0] req_a0, req_a1, req_b0, req_b1;
    logic [4:0]  req_shamt0, req_shamt1;
    logic [1:0]  rsp_ready;

    logic [1:0]  req_ready, rsp_valid;
    logic [31:0] rsp_result, alu_a, alu_b, alu_result;
    logic        rsp_ovf, rsp_id, alu_ovf, busy;
    logic [4:0]  alu_shamt, alu_op;

    logic [1:0]  f_req_ready, f_rsp_valid;
    logic [31:0] f_rsp_result, f_alu_a, f_alu_b, f_alu_result;
    logic        f_rsp_ovf, f_rsp_id, f_alu_ovf, f_busy;
    logic [4:0]  f_alu_shamt, f_alu_op;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic logic [32:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] r;
        logic        v;
        v = 1'b0;
        case (op)
            5'd0: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            5'd1: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            5'd2: r = a & b;
            5'd3: r = a << sh;
            default: r = a ^ b;
        endcase
        return {v, r};
    endfunction

    assign {alu_ovf, alu_result}     = alu_f(alu_op, alu_a, alu_b, alu_shamt);
    assign {f_alu_ovf, f_alu_result} = alu_f(f_alu_op, f_alu_a, f_alu_b, f_alu_shamt);

    alu_arbiter #(.RR(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .req_shamt0(req_shamt0), .req_shamt1(req_shamt1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_ovf(rsp_ovf), .rsp_id(rsp_id),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_op(alu_op),
        .alu_result(alu_result), .alu_ovf(alu_ovf), .busy(busy)
    );

    alu_arbiter #(.RR(1'b0)) dut_fp (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(f_req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .req_shamt0(req_shamt0), .req_shamt1(req_shamt1),
        .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(f_rsp_result), .rsp_ovf(f_rsp_ovf), .rsp_id(f_rsp_id),
        .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_shamt(f_alu_shamt), .alu_op(f_alu_op),
        .alu_result(f_alu_result), .alu_ovf(f_alu_ovf), .busy(f_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          port;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] er;
        logic        eo;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        if (v.port == 0) begin
            req_op0 = v.op; req_a0 = v.a; req_b0 = v.b; req_shamt0 = v.sh;
            req_valid = 2'b01;
        end else begin
            req_op1 = v.op; req_a1 = v.a; req_b1 = v.b; req_shamt1 = v.sh;
            req_valid = 2'b10;
        end
    endtask

    task automatic do_reset();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    // Single uncontended transaction on the DUT with rsp_ready high.
    task automatic run_vec(input vec_t v, input string tag);
        logic [1:0] oh;
        oh = (v.port == 0) ? 2'b01 : 2'b10;
        drive(v);
        #1;
        chk({tag, " c0 req_ready"}, {30'd0, req_ready}, {30'd0, oh});
        chk({tag, " c0 busy"}, {31'd0, busy}, 32'd0);
        step();
        req_valid = 2'b00;
        #1;
        chk({tag, " c1 alu_a"}, alu_a, v.a);
        chk({tag, " c1 alu_b"}, alu_b, v.b);
        chk({tag, " c1 alu_op"}, {27'd0, alu_op}, {27'd0, v.op});
        chk({tag, " c1 alu_shamt"}, {27'd0, alu_shamt}, {27'd0, v.sh});
        chk({tag, " c1 busy"}, {31'd0, busy}, 32'd1);
        chk({tag, " c1 rsp_valid"}, {30'd0, rsp_valid}, 32'd0);
        step();
        chk({tag, " c2 rsp_valid"}, {30'd0, rsp_valid}, {30'd0, oh});
        chk({tag, " c2 rsp_result"}, rsp_result, v.er);
        chk({tag, " c2 rsp_ovf"}, {31'd0, rsp_ovf}, {31'd0, v.eo});
        chk({tag, " c2 rsp_id"}, {31'd0, rsp_id}, v.port);
        step();
        chk({tag, " c3 busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " c3 rsp_valid"}, {30'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        vec_t v;
        logic [1:0] expg;
        int w;

        vecs[0] = '{0, 5'd0, 32'd5,         32'd7,  5'd0,  32'd12,        1'b0};
        vecs[1] = '{1, 5'd0, 32'h7FFF_FFFF, 32'd1,  5'd0,  32'h8000_0000, 1'b1};
        vecs[2] = '{1, 5'd1, 32'h8000_0000, 32'd1,  5'd0,  32'h7FFF_FFFF, 1'b1};
        vecs[3] = '{0, 5'd2, 32'h0000_F0F0, 32'h0000_0FF0, 5'd0, 32'h0000_00F0, 1'b0};
        vecs[4] = '{1, 5'd3, 32'd1,         32'd0,  5'd31, 32'h8000_0000, 1'b0};
        vecs[5] = '{0, 5'd1, 32'd3,         32'd5,  5'd0,  32'hFFFF_FFFE, 1'b0};

        req_valid = 2'b00; rsp_ready = 2'b11;
        req_op0 = '0; req_op1 = '0; req_a0 = '0; req_a1 = '0;
        req_b0 = '0; req_b1 = '0; req_shamt0 = '0; req_shamt1 = '0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        step();
        chk("rst req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst rsp_result", rsp_result, 32'd0);
        chk("rst rsp_ovf", {31'd0, rsp_ovf}, 32'd0);
        chk("rst rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("rst alu_a", alu_a, 32'd0);
        chk("rst alu_b", alu_b, 32'd0);
        chk("rst alu_op", {27'd0, alu_op}, 32'd0);
        chk("rst alu_shamt", {27'd0, alu_shamt}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Round-robin with both ports continuously valid.
        do_reset();
        req_op0 = 5'd0; req_a0 = 32'd10; req_b0 = 32'd1; req_shamt0 = '0;
        req_op1 = 5'd0; req_a1 = 32'd20; req_b1 = 32'd2; req_shamt1 = '0;
        req_valid = 2'b11;
        #1;
        for (int g = 0; g < 4; g++) begin
            expg = (g % 2 == 0) ? 2'b01 : 2'b10;
            w = 0;
            while (req_ready == 2'b00 && w < 10) begin
                step();
                w++;
            end
            chk($sformatf("rr grant%0d", g), {30'd0, req_ready}, {30'd0, expg});
            step();
            chk($sformatf("rr alu_a%0d", g), alu_a, (g % 2 == 0) ? 32'd10 : 32'd20);
            step();
            chk($sformatf("rr rsp_valid%0d", g), {30'd0, rsp_valid}, {30'd0, expg});
            chk($sformatf("rr rsp_result%0d", g), rsp_result, (g % 2 == 0) ? 32'd11 : 32'd22);
            step();
        end

        // Fixed priority instance: port 0 wins until it deasserts.
        do_reset();
        req_valid = 2'b11;
        #1;
        for (int g = 0; g < 5; g++) begin
            expg = (g < 4) ? 2'b01 : 2'b10;
            if (g == 4) begin
                req_valid = 2'b10;
                #1;
            end
            w = 0;
            while (f_req_ready == 2'b00 && w < 10) begin
                step();
                w++;
            end
            chk($sformatf("fp grant%0d", g), {30'd0, f_req_ready}, {30'd0, expg});
            step();
            step();
            chk($sformatf("fp rsp_valid%0d", g), {30'd0, f_rsp_valid}, {30'd0, expg});
            chk($sformatf("fp rsp_result%0d", g), f_rsp_result, (g < 4) ? 32'd11 : 32'd22);
            step();
        end
        req_valid = 2'b00;

        // Backpressure: port-0 response held while port 1 waits.
        do_reset();
        rsp_ready = 2'b00;
        req_op0 = 5'd0; req_a0 = 32'h7FFF_FFFF; req_b0 = 32'd1;
        req_valid = 2'b01;
        #1;
        chk("bp grant0", {30'd0, req_ready}, 32'd1);
        step();
        req_op1 = 5'd1; req_a1 = 32'd50; req_b1 = 32'd8;
        req_valid = 2'b10;
        rsp_ready = 2'b10;
        #1;
        chk("bp exec req_ready", {30'd0, req_ready}, 32'd0);
        step();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp hold%0d rsp_valid", i), {30'd0, rsp_valid}, 32'd1);
            chk($sformatf("bp hold%0d rsp_result", i), rsp_result, 32'h8000_0000);
            chk($sformatf("bp hold%0d rsp_ovf", i), {31'd0, rsp_ovf}, 32'd1);
            chk($sformatf("bp hold%0d rsp_id", i), {31'd0, rsp_id}, 32'd0);
            chk($sformatf("bp hold%0d req_ready", i), {30'd0, req_ready}, 32'd0);
            step();
        end
        rsp_ready = 2'b11;
        #1;
        chk("bp rsp hs req_ready", {30'd0, req_ready}, 32'd0);
        step();
        chk("bp grant1", {30'd0, req_ready}, 32'd2);
        chk("bp idle rsp_valid", {30'd0, rsp_valid}, 32'd0);
        step();
        req_valid = 2'b00;
        step();
        chk("bp p1 rsp_valid", {30'd0, rsp_valid}, 32'd2);
        chk("bp p1 rsp_result", rsp_result, 32'd42);
        chk("bp p1 rsp_id", {31'd0, rsp_id}, 32'd1);
        step();
        chk("bp p1 busy", {31'd0, busy}, 32'd0);

        // Async reset during EXEC drops the request.
        do_reset();
        v = '{0, 5'd0, 32'h1234_5678, 32'h1111_1111, 5'd4, 32'h2345_6789, 1'b0};
        drive(v);
        step();
        chk("ar exec busy", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar busy", {31'd0, busy}, 32'd0);
        chk("ar alu_a", alu_a, 32'd0);
        chk("ar alu_b", alu_b, 32'd0);
        chk("ar alu_shamt", {27'd0, alu_shamt}, 32'd0);
        chk("ar req_ready", {30'd0, req_ready}, 32'd0);
        chk("ar rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("ar rsp_result", rsp_result, 32'd0);
        req_valid = 2'b00;
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("ar post%0d rsp_valid", i), {30'd0, rsp_valid}, 32'd0);
            chk($sformatf("ar post%0d busy", i), {31'd0, busy}, 32'd0);
        end
        v = '{1, 5'd1, 32'd9, 32'd4, 5'd0, 32'd5, 1'b0};
        run_vec(v, "ar after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single execute-stage ALU between two requesters (port 0: pipeline E stage, port 1: auxiliary/debug issue port) through valid/ready handshakes. A small state machine arbitrates, registers the winner's operands onto the ALU inputs, captures Result/Overflow one cycle later, and holds the response until the owning requester accepts it. The ALU itself stays purely combinational outside this block; the arbiter only drives its inputs and samples its outputs.

## Interface
- `RR`, 1, 1 = round-robin arbitration, 0 = fixed priority to port 0
- `clk`  in  1  clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately
- `req_valid`  in  2  per-port request valid (bit i = port i)
- `req_ready`  out  2  per-port accept; one-hot or zero
- `req_op0`, `req_op1`  in  5  ALU opcode per port, passed through opaquely
- `req_a0`, `req_a1`  in  32  operand A per port
- `req_b0`, `req_b1`  in  32  operand B per port
- `req_shamt0`, `req_shamt1`  in  5  shift amount per port
- `rsp_valid`  out  2  per-port response valid; one-hot or zero
- `rsp_ready`  in  2  per-port response accept
- `rsp_result`  out  32  captured ALU result, shared by both ports
- `rsp_ovf`  out  1  captured ALU overflow
- `rsp_id`  out  1  port that owns the current response
- `alu_a`, `alu_b`  out  32  registered ALU operand drives
- `alu_shamt`  out  5  registered ALU shift amount
- `alu_op`  out  5  registered ALU opcode
- `alu_result`  in  32  ALU Result
- `alu_ovf`  in  1  ALU Overflow
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, EXEC, RESP.
- IDLE:
  - Arbitrate over `req_valid`. `req_ready[i]` = (state==IDLE) && grant[i], driven combinationally.
  - On handshake, register that port's op/a/b/shamt into `alu_*`, record the owner, go to EXEC.
- EXEC: exactly one cycle. Sample `alu_result`/`alu_ovf` into `rsp_result`/`rsp_ovf`, then go to RESP.
- RESP:
  - `rsp_valid[owner]`=1.
  - On `rsp_ready[owner]`=1, clear it and go to IDLE.
  - `rsp_ready` of the non-owner port is ignored.
- Arbitration with RR=1:
  - Pointer `last` (reset 1) so port 0 wins the first tie.
  - Single requester always wins.
  - Both requesting: the port ≠ `last` wins; `last` updates on each grant.
- Arbitration with RR=0: port 0 always wins ties; `last` unused.
- `alu_*` hold their last values outside EXEC. They are not zeroed, so the ALU output is stable.
- Opcode, shamt and operands are opaque to the block; no decoding. `rsp_ovf` is whatever the ALU reports (nonzero only for add/sub).
- A requester may drop `req_valid` before a handshake; no grant occurs and no state change.
- A response held indefinitely (`rsp_ready` low) stalls both ports. There is no timeout.

## Timing
- Reset (async, `reset`=0): state IDLE, `last`=1, `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_ovf`=0, `rsp_id`=0, `alu_a`/`alu_b`=0, `alu_shamt`=0, `alu_op`=0, `busy`=0.
- Reset mid-operation drops the in-flight request; no response is ever produced for it.
- Cycle 0: request handshake in IDLE.
- Cycle 1: EXEC; `alu_*` show the new operands.
- Cycle 2: `rsp_valid` high at the earliest.
- Minimum issue interval is 3 cycles (handshake, EXEC, RESP with immediate ready). The next `req_ready` can rise in cycle 3.
- `rsp_result`, `rsp_ovf` and `rsp_id` are stable from RESP entry until the response handshake.
- No request is accepted in the same cycle as a response handshake.

## Test plan
- Single request, no contention:
  - Stimulus: port 0 requests add a=5, b=7, rsp_ready tied 1.
  - Required: req_ready[0] in cycle 0, alu_a=5 and alu_b=7 in cycle 1, rsp_valid[0] with result 12, ovf 0, rsp_id 0 in cycle 2, busy low again in cycle 3.
- Overflow capture:
  - Stimulus: port 1 requests add a=0x7FFFFFFF, b=1.
  - Required: rsp_result 0x80000000, rsp_ovf 1, rsp_id 1.
  - Stimulus: port 1 requests sub a=0x80000000, b=1.
  - Required: rsp_ovf 1.
- Round-robin, both ports continuously valid (RR=1):
  - Required: grants alternate 0,1,0,1.
  - Required: every response is routed to the correct rsp_valid bit with that port's operands.
- Fixed priority (RR=0), both ports continuously valid:
  - Required: port 0 granted every time; port 1 never granted until port 0 deasserts.
- Backpressure:
  - Stimulus: rsp_ready[0] held 0 for 10 cycles while port 1 requests.
  - Required: rsp_result/rsp_ovf/rsp_id hold steady, req_ready stays 0, and port 1 is granted only after the port-0 response handshake.
- Async reset mid-op:
  - Stimulus: reset=0 asserted during EXEC.
  - Required: all outputs go to their reset values immediately, no rsp_valid ever appears for the dropped request, and the first request after release is served normally.
